// File: rtl/map_dot_clear.sv
// Pac-Man dot eater: reads one map row, clears the dot under the tile if present,
// and counts how many dots have been eaten.
module map_dot_clear #(
    parameter int unsigned ROWS   = 32,
    parameter int unsigned COLS   = 160,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(ROWS)-1:0]  req_row,
    input  logic [7:0]               req_col,
    output logic                     done,
    output logic                     dot_found,
    output logic                     err,
    output logic [15:0]              eaten_count,
    output logic [$clog2(ROWS)-1:0]  ram_addr,
    output logic [COLS-1:0]          ram_wrdata,
    output logic                     ram_wren,
    input  logic [COLS-1:0]          ram_rddata
);

    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCheck,
        StWrite,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  addr_q, addr_d;
    logic [7:0]        col_q, col_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [COLS-1:0]   buf_q, buf_d;
    logic              dot_q, dot_d;
    logic              err_q, err_d;
    logic [15:0]       eaten_q, eaten_d;
    logic [COLS-1:0]   sel_mask;

    // Column 0 lives in the MSB of the row word.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < int'(COLS); i++) begin
            sel_mask[i] = (32'(COLS - 1 - i) == 32'(col_q));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            col_q    <= '0;
            rd_cnt_q <= '0;
            buf_q    <= '0;
            dot_q    <= 1'b0;
            err_q    <= 1'b0;
            eaten_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            col_q    <= col_d;
            rd_cnt_q <= rd_cnt_d;
            buf_q    <= buf_d;
            dot_q    <= dot_d;
            err_q    <= err_d;
            eaten_q  <= eaten_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        col_d      = col_q;
        rd_cnt_d   = rd_cnt_q;
        buf_d      = buf_q;
        dot_d      = dot_q;
        err_d      = err_q;
        eaten_d    = eaten_q;
        req_ready  = 1'b0;
        done       = 1'b0;
        dot_found  = 1'b0;
        err        = 1'b0;
        ram_wren   = 1'b0;
        ram_wrdata = '0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    dot_d = 1'b0;
                    err_d = 1'b0;
                    // Out-of-range column never touches the RAM or the address.
                    if (32'(req_col) >= COLS) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        addr_d   = req_row;
                        col_d    = req_col;
                        rd_cnt_d = '0;
                        state_d  = StRead;
                    end
                end
            end
            StRead: begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d = StCheck;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            StCheck: begin
                buf_d = ram_rddata;
                if (|(ram_rddata & sel_mask)) begin
                    state_d = StWrite;
                end else begin
                    state_d = StDone;
                end
            end
            StWrite: begin
                ram_wren   = 1'b1;
                ram_wrdata = buf_q & ~sel_mask;
                dot_d      = 1'b1;
                // Count becomes visible on the done cycle; saturates rather than wraps.
                if (eaten_q != 16'hFFFF) begin
                    eaten_d = eaten_q + 16'd1;
                end
                state_d = StDone;
            end
            StDone: begin
                done      = 1'b1;
                dot_found = dot_q;
                err       = err_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ram_addr    = addr_q;
    assign eaten_count = eaten_q;

endmodule

// File: tb/tb_map_dot_clear.sv
// Bench for map_dot_clear: behavioural map RAM with read latency, scoreboard of
// expected completions, directed hit/miss/error/busy/reset/saturation steps.
module tb_map_dot_clear;

    localparam int unsigned ROWS   = 32;
    localparam int unsigned COLS   = 160;
    localparam int unsigned RD_LAT = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_row;
    logic [7:0]   req_col;
    logic         done;
    logic         dot_found;
    logic         err;
    logic [15:0]  eaten_count;
    logic [4:0]   ram_addr;
    logic [159:0] ram_wrdata;
    logic         ram_wren;
    logic [159:0] ram_rddata;

    always #5 clock = ~clock;

    map_dot_clear #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .RD_LAT (RD_LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_row     (req_row),
        .req_col     (req_col),
        .done        (done),
        .dot_found   (dot_found),
        .err         (err),
        .eaten_count (eaten_count),
        .ram_addr    (ram_addr),
        .ram_wrdata  (ram_wrdata),
        .ram_wren    (ram_wren),
        .ram_rddata  (ram_rddata)
    );

    function automatic logic [159:0] init_row(input int r);
        logic [159:0] v;
        v = '0;
        if (r == 20) v = {160{1'b1}};
        if (r == 13) v = 160'(1) << 154;
        return v;
    endfunction

    // Map RAM model: two-stage read pipeline, write on the clock edge.
    logic         preload;
    logic [159:0] mem [ROWS];
    logic [159:0] p1, p2;
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < int'(ROWS); i++) mem[i] <= init_row(i);
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_wrdata;
        end
        p1 <= mem[ram_addr];
        p2 <= p1;
    end
    assign ram_rddata = p2;

    typedef struct {
        int           done_at;
        int           wren_at;
        logic [159:0] wdata;
        logic         dot;
        logic         err;
        logic [4:0]   addr;
    } exp_t;

    exp_t         sb[$];
    logic [159:0] ref_map [ROWS];
    logic [15:0]  exp_count;
    logic [4:0]   last_addr;
    logic [159:0] row_now;
    int           total = 0;
    int           bad   = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request (caller is at a negedge), push its expectation, wait for the accept edge.
    task automatic start_req(input logic [4:0] r, input logic [7:0] c);
        exp_t e;
        int   idx;
        req_valid = 1'b1;
        req_row   = r;
        req_col   = c;
        check("ready_before_accept", {159'b0, req_ready}, 160'd1);
        e.wdata   = '0;
        e.wren_at = 0;
        e.dot     = 1'b0;
        e.err     = 1'b0;
        if (int'(c) >= int'(COLS)) begin
            e.done_at = 1;
            e.err     = 1'b1;
            e.addr    = last_addr;
        end else begin
            e.addr    = r;
            last_addr = r;
            idx       = int'(COLS) - 1 - int'(c);
            if (ref_map[r][idx]) begin
                ref_map[r][idx] = 1'b0;
                e.wdata   = ref_map[r];
                e.wren_at = RD_LAT + 2;
                e.done_at = RD_LAT + 3;
                e.dot     = 1'b1;
                if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            end else begin
                e.done_at = RD_LAT + 2;
            end
        end
        sb.push_back(e);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    // Watch the busy cycles until done (bounded), then compare with the scoreboard head.
    task automatic observe();
        exp_t         e;
        int           done_at;
        int           wren_at;
        logic [159:0] wd;
        logic         d;
        logic         er;
        e       = sb.pop_front();
        done_at = 0;
        wren_at = 0;
        wd      = '0;
        d       = 1'b0;
        er      = 1'b0;
        for (int n = 1; n <= 20 && done_at == 0; n++) begin
            @(negedge clock);
            check("ram_addr_busy", {155'b0, ram_addr}, {155'b0, e.addr});
            check("ready_busy", {159'b0, req_ready}, 160'd0);
            if (ram_wren) begin
                wren_at = n;
                wd      = ram_wrdata;
            end else begin
                check("wrdata_no_wren", ram_wrdata, 160'd0);
            end
            if (done) begin
                done_at = n;
                d       = dot_found;
                er      = err;
            end else begin
                check("flags_without_done", {158'b0, dot_found, err}, 160'd0);
            end
        end
        check("done_cycle", 160'(done_at), 160'(e.done_at));
        check("wren_cycle", 160'(wren_at), 160'(e.wren_at));
        check("wrdata", wd, e.wdata);
        check("dot_found", {159'b0, d}, {159'b0, e.dot});
        check("err", {159'b0, er}, {159'b0, e.err});
        @(negedge clock);
        check("eaten_count", {144'b0, eaten_count}, {144'b0, exp_count});
        check("ready_idle", {159'b0, req_ready}, 160'd1);
    endtask

    initial begin
        reset     = 1'b1;
        preload   = 1'b1;
        req_valid = 1'b0;
        req_row   = '0;
        req_col   = '0;
        exp_count = '0;
        last_addr = '0;
        for (int i = 0; i < int'(ROWS); i++) ref_map[i] = init_row(i);

        repeat (2) @(negedge clock);
        preload = 1'b0;
        check("rst_ready", {159'b0, req_ready}, 160'd1);
        check("rst_flags", {157'b0, done, dot_found, err}, 160'd0);
        check("rst_wren", {159'b0, ram_wren}, 160'd0);
        check("rst_addr", {155'b0, ram_addr}, 160'd0);
        check("rst_wrdata", ram_wrdata, 160'd0);
        check("rst_count", {144'b0, eaten_count}, 160'd0);

        // Hit right after reset release, then a miss on the same tile.
        reset = 1'b0;
        start_req(5'd20, 8'd0);
        observe();
        start_req(5'd20, 8'd0);
        observe();

        // Column out of range.
        start_req(5'd13, 8'd160);
        observe();

        // Second request held on the bus while the first is busy.
        start_req(5'd20, 8'd1);
        req_valid = 1'b1;
        req_row   = 5'd13;
        req_col   = 8'd5;
        observe();
        start_req(5'd13, 8'd5);
        observe();

        // Reset in the WRITE cycle.
        req_valid = 1'b1;
        req_row   = 5'd20;
        req_col   = 8'd2;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (RD_LAT + 1) @(posedge clock);
        #1;
        check("wren_in_write", {159'b0, ram_wren}, 160'd1);
        reset = 1'b1;
        #1;
        check("wren_drop_on_reset", {159'b0, ram_wren}, 160'd0);
        check("wrdata_drop_on_reset", ram_wrdata, 160'd0);
        check("ready_on_reset", {159'b0, req_ready}, 160'd1);
        check("count_on_reset", {144'b0, eaten_count}, 160'd0);
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        exp_count = '0;
        last_addr = '0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            check("no_done_after_abort", {159'b0, done}, 160'd0);
        end
        row_now = mem[20];
        check("aborted_row_intact", {159'b0, row_now[157]}, 160'd1);

        // Saturation: preload the counter one below the top, then two hits.
        force dut.eaten_q = 16'hFFFE;
        #1;
        release dut.eaten_q;
        exp_count = 16'hFFFE;
        check("count_preset", {144'b0, eaten_count}, {144'b0, exp_count});
        start_req(5'd20, 8'd2);
        observe();
        start_req(5'd20, 8'd3);
        observe();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/map_dot_clear.md
MAP_DOT_CLEAR -- requirements
Module: map_dot_clear

Interface
REQ-001 Parameter: ROWS, 32, map rows held in map RAM (row address 5 bits).
REQ-002 Parameter: COLS, 160, map columns per row (RAM word width in bits).
REQ-003 Parameter: RD_LAT, 2, map RAM port-b read latency in cycles (address to q).
REQ-004 clock  in  1  single system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  eat request present.
REQ-007 req_ready  out  1  block idle and able to accept a request.
REQ-008 req_row  in  5  map row of pacman tile.
REQ-009 req_col  in  8  map column of pacman tile.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 dot_found  out  1  dot was present and cleared; valid only with done.
REQ-012 err  out  1  request column out of range; valid only with done.
REQ-013 eaten_count  out  16  running count of dots cleared.
REQ-014 ram_addr  out  5  map RAM port-b address.
REQ-015 ram_wrdata  out  160  map RAM port-b write data.
REQ-016 ram_wren  out  1  map RAM port-b write enable.
REQ-017 ram_rddata  in  160  map RAM port-b read data (q_b).

Function
REQ-018 FSM states SHALL be IDLE, READ, CHECK, WRITE, DONE; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept SHALL occur on a rising edge with req_valid=1 and req_ready=1 (cycle k); req_row/req_col SHALL be latched at that edge.
REQ-020 req_valid while not in IDLE SHALL be ignored; no queuing.
REQ-021 Accepted req_col >= COLS: IDLE->DONE, no RAM read or write, done at k+1 with err=1, dot_found=0, eaten_count unchanged.
REQ-022 Valid request: IDLE->READ; ram_addr SHALL equal the latched row from k+1 until return to IDLE.
REQ-023 READ SHALL last exactly RD_LAT cycles (k+1..k+RD_LAT), then ->CHECK.
REQ-024 CHECK (cycle k+RD_LAT+1) SHALL capture ram_rddata into a 160-bit row buffer and test bit [COLS-1-col] (column 0 = MSB).
REQ-025 Bit set: CHECK->WRITE; WRITE SHALL last one cycle with ram_wren=1, ram_wrdata = buffer with only that bit cleared; then ->DONE (done at k+RD_LAT+3, dot_found=1).
REQ-026 Bit clear: CHECK->DONE, no write (done at k+RD_LAT+2, dot_found=0, err=0).
REQ-027 DONE SHALL last one cycle with done=1, then ->IDLE; next request acceptable on the following cycle.
REQ-028 ram_wren SHALL be 0 in every state except WRITE; ram_wrdata SHALL be 0 when ram_wren=0.
REQ-029 eaten_count SHALL increment by 1 on the DONE cycle when dot_found=1, saturating at 16'hFFFF (no wrap).
REQ-030 dot_found and err SHALL be 0 whenever done=0.
REQ-031 Row values >= ROWS are not range-checked; the low 5 bits are used as-is.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, req_ready=1, done=0, dot_found=0, err=0, ram_wren=0, ram_addr=0, ram_wrdata=0, eaten_count=0, row buffer=0.
REQ-033 reset asserted mid-operation (including during WRITE) SHALL abort with no further RAM write and no done pulse; in-flight request is lost.
REQ-034 First accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-035 Hit: RAM row 20 = all ones, request (20, 0) at k -> ram_wren=1 at k+4 with wrdata=160'h7FFF...F, done at k+5, dot_found=1, eaten_count=1; reread row 20 bit 159 = 0.
REQ-036 Miss: request (20, 0) again -> no ram_wren, done at k+4, dot_found=0, eaten_count stays 1.
REQ-037 Range error: request (13, 160) -> done at k+1, err=1, ram_addr never changes to 13, no write.
REQ-038 Busy ignore: hold req_valid=1 with (13, 5) during a running (20, 1) request -> req_ready=0 while busy, (13, 5) accepted only on the cycle after done.
REQ-039 Reset mid-WRITE: assert reset during WRITE cycle -> ram_wren drops same cycle, no done, eaten_count=0, req_ready=1.
REQ-040 Saturation: preset eaten_count path with 65535 hits (or force) then one more hit -> eaten_count stays 16'hFFFF.
